// File: rtl/udma_tx_pkg.sv
// Shared types and helpers for the uDMA TX stream channel.
// Covers the channel states, the consumer beat-size encoding and the read-data lane alignment.
package udma_tx_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    DS_BYTE     = 2'd0,
    DS_HALF     = 2'd1,
    DS_WORD     = 2'd2,
    DS_WORD_ALT = 2'd3
  } datasize_t;

  function automatic logic [2:0] step_decode(input logic [1:0] ds);
    case (datasize_t'(ds))
      DS_BYTE: return 3'd1;
      DS_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Bytes beyond the end of the word shift in as zero, so a misaligned beat keeps only the bytes the word holds.
  function automatic logic [31:0] lane_extract(input logic [31:0] rdata,
                                               input logic [1:0]  lane,
                                               input logic [2:0]  step);
    logic [31:0] shifted;
    shifted = rdata >> {lane, 3'b000};
    case (step)
      3'd1:    return {24'b0, shifted[7:0]};
      3'd2:    return {16'b0, shifted[15:0]};
      default: return shifted;
    endcase
  endfunction

endpackage

// File: rtl/udma_tx_fifo.sv
// Synchronous FIFO that buffers aligned read beats for the TX stream.
// A flush empties it in one cycle; a push is accepted while full only when there is a pop in the same cycle.
module udma_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       pop_data_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             full, do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty_o = (count == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full | do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem[wr_ptr] <= push_data_i;
  end

  assign pop_data_o = mem[rd_ptr];
  assign count_o    = count;

endmodule

// File: rtl/udma_tx_stream_channel.sv
// uDMA TX channel: fetches L2 data per consumer grant, aligns it, and streams it out through a small FIFO.
// Supports one queued shadow transfer, continuous reload and clear/abort.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no active transfer; waiting for cfg_en_i with nonzero size
// ST_RUN  | transfer active; grants issue fetches, shadow may be queued
module udma_tx_stream_channel
  import udma_tx_pkg::*;
#(
  parameter int L2_AWIDTH_NOAL = 12,
  parameter int TRANS_SIZE     = 16,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      sys_clk_i,
  input  logic                      rst_i,
  input  logic [L2_AWIDTH_NOAL-1:0] cfg_startaddr_i,
  input  logic [TRANS_SIZE-1:0]     cfg_size_i,
  input  logic                      cfg_continuous_i,
  input  logic                      cfg_en_i,
  input  logic                      cfg_clr_i,
  output logic                      cfg_en_o,
  output logic                      cfg_pending_o,
  output logic [L2_AWIDTH_NOAL-1:0] cfg_curr_addr_o,
  output logic [TRANS_SIZE-1:0]     cfg_bytes_left_o,
  output logic                      mem_req_o,
  output logic [L2_AWIDTH_NOAL-1:0] mem_addr_o,
  input  logic [31:0]               mem_rdata_i,
  input  logic                      data_tx_req_i,
  output logic                      data_tx_gnt_o,
  input  logic [1:0]                data_tx_datasize_i,
  output logic [31:0]               data_tx_o,
  output logic                      data_tx_valid_o,
  input  logic                      data_tx_ready_i,
  output logic                      eot_o
);
  localparam int AW = L2_AWIDTH_NOAL;
  localparam int TS = TRANS_SIZE;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t        state;
  logic [AW-1:0] curr_addr, start_addr, shadow_addr;
  logic [TS-1:0] bytes_left, start_size, shadow_size;
  logic          continuous, shadow_cont, shadow_valid;
  logic          inflight, inflight_last;
  logic [1:0]    inflight_lane;
  logic [2:0]    inflight_step, step;
  logic          gnt, is_final, en_ok;
  logic [CW-1:0] fifo_count, occupancy;
  logic          fifo_empty, fifo_pop;
  logic [32:0]   fifo_head;

  assign step      = step_decode(data_tx_datasize_i);
  assign is_final  = (TS'(step) >= bytes_left);
  assign en_ok     = cfg_en_i & (cfg_size_i != '0);
  // An in-flight read already owns a FIFO slot, so it counts toward occupancy.
  assign occupancy = fifo_count + CW'(inflight);
  assign gnt       = data_tx_req_i & (state == ST_RUN) & ~cfg_clr_i &
                     (occupancy < CW'(FIFO_DEPTH));

  always_ff @(posedge sys_clk_i) begin
    if (rst_i || cfg_clr_i) begin
      state         <= ST_IDLE;
      curr_addr     <= '0;
      bytes_left    <= '0;
      start_addr    <= '0;
      start_size    <= '0;
      continuous    <= 1'b0;
      shadow_valid  <= 1'b0;
      shadow_addr   <= '0;
      shadow_size   <= '0;
      shadow_cont   <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      inflight_lane <= '0;
      inflight_step <= '0;
    end else begin
      inflight      <= gnt;
      inflight_last <= is_final;
      inflight_lane <= curr_addr[1:0];
      inflight_step <= step;
      case (state)
        ST_IDLE: begin
          if (en_ok) begin
            state      <= ST_RUN;
            curr_addr  <= cfg_startaddr_i;
            bytes_left <= cfg_size_i;
            start_addr <= cfg_startaddr_i;
            start_size <= cfg_size_i;
            continuous <= cfg_continuous_i;
          end
        end
        default: begin
          if (gnt && is_final) begin
            // A start arriving on the final grant is the newest request, so it wins over an older shadow.
            if (en_ok) begin
              curr_addr    <= cfg_startaddr_i;
              bytes_left   <= cfg_size_i;
              start_addr   <= cfg_startaddr_i;
              start_size   <= cfg_size_i;
              continuous   <= cfg_continuous_i;
              shadow_valid <= 1'b0;
            end else if (shadow_valid) begin
              curr_addr    <= shadow_addr;
              bytes_left   <= shadow_size;
              start_addr   <= shadow_addr;
              start_size   <= shadow_size;
              continuous   <= shadow_cont;
              shadow_valid <= 1'b0;
            end else if (continuous) begin
              curr_addr  <= start_addr;
              bytes_left <= start_size;
            end else begin
              state      <= ST_IDLE;
              curr_addr  <= curr_addr + AW'(step);
              bytes_left <= '0;
            end
          end else begin
            if (en_ok) begin
              shadow_valid <= 1'b1;
              shadow_addr  <= cfg_startaddr_i;
              shadow_size  <= cfg_size_i;
              shadow_cont  <= cfg_continuous_i;
            end
            if (gnt) begin
              curr_addr  <= curr_addr + AW'(step);
              bytes_left <= bytes_left - TS'(step);
            end
          end
        end
      endcase
    end
  end

  udma_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (33)
  ) u_fifo (
    .clk_i       (sys_clk_i),
    .rst_i       (rst_i),
    .flush_i     (cfg_clr_i),
    .push_i      (inflight & ~cfg_clr_i),
    .push_data_i ({inflight_last, lane_extract(mem_rdata_i, inflight_lane, inflight_step)}),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_head),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign fifo_pop         = data_tx_ready_i & ~fifo_empty;
  assign data_tx_valid_o  = ~fifo_empty;
  assign data_tx_o        = fifo_empty ? 32'h0 : fifo_head[31:0];
  assign eot_o            = fifo_pop & fifo_head[32];
  assign data_tx_gnt_o    = gnt;
  assign mem_req_o        = gnt;
  assign mem_addr_o       = {curr_addr[AW-1:2], 2'b00};
  assign cfg_en_o         = (state == ST_RUN);
  assign cfg_pending_o    = shadow_valid;
  assign cfg_curr_addr_o  = curr_addr;
  assign cfg_bytes_left_o = bytes_left;

endmodule
